// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file, shared with a WISHBONE slave port.
// The target answers the write-pointer-then-data and repeated-start-read protocol,
// never drives SCL and never stretches the clock. SDA is open-drain (0 or Z).
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_sel_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       wb_err_o,
  output logic       wb_rty_o,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       i2c_wr_o,
  output logic [3:0] i2c_wr_adr_o,
  output logic       busy_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, DATA_WR, WR_ACK, DATA_RD, RD_ACK
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA through the conditioning chain.
  logic [1:0]    sync_p0, sync_p1, filt, filt_d;
  logic [CW-1:0] flt_cnt [2];
  logic          sda_in;
  logic          scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          ack_ph, ack_ph_nxt;
  logic          sda_oe, sda_oe_nxt;
  logic          busy_nxt;

  logic          sr_shift_in, sr_shift_out, sr_load;
  logic          ptr_set, ptr_inc, reg_wr;
  logic [3:0]    rd_idx;
  logic [7:0]    sr;
  logic [7:0]    rx_byte;
  logic [3:0]    ptr;
  logic [7:0]    regs [16];

  logic          wb_req;
  logic          wb_we_q;
  logic [3:0]    wb_adr_q;
  logic [7:0]    wb_dat_q;
  logic          wb_wr_fire;
  logic          unused_sel;

  assign unused_sel = wb_sel_i;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;

  // Open-drain pad: reset releases the line combinationally, not a cycle later.
  assign SDA    = (sda_oe && !rst_i) ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  // Two-flop synchronizer followed by a run-length filter on SCL and SDA.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync_p0 <= {SCL, sda_in};
      sync_p1 <= sync_p0;
      filt_d  <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i]    <= sync_p1[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_d[1];
  assign scl_fall  = ~filt[1] & filt_d[1];
  assign start_det = filt[1] & filt_d[1] & filt_d[0] & ~filt[0];
  assign stop_det  = filt[1] & filt_d[1] & ~filt_d[0] & filt[0];
  assign rx_byte   = {sr[6:0], sda_f};

  // Protocol state register and registered pad/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      ack_ph       <= 1'b0;
      sda_oe       <= 1'b0;
      busy_o       <= 1'b0;
      i2c_wr_o     <= 1'b0;
      i2c_wr_adr_o <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ack_ph   <= ack_ph_nxt;
      sda_oe   <= sda_oe_nxt;
      busy_o   <= busy_nxt;
      i2c_wr_o <= reg_wr;
      if (reg_wr) i2c_wr_adr_o <= ptr;
    end
  end

  // Next-state logic; ack_ph marks the second half of an ACK slot (SDA held low).
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    ack_ph_nxt   = ack_ph;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy_o;
    sr_shift_in  = 1'b0;
    sr_shift_out = 1'b0;
    sr_load      = 1'b0;
    ptr_set      = 1'b0;
    ptr_inc      = 1'b0;
    reg_wr       = 1'b0;
    rd_idx       = ptr;
    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      ack_ph_nxt  = 1'b0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt  = IDLE;
      ack_ph_nxt = 1'b0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            sr_shift_in = 1'b1;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == I2C_ADDR) begin
                state_nxt  = ADDR_ACK;
                ack_ph_nxt = 1'b0;
              end else begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              ack_ph_nxt = 1'b1;
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
            end else begin
              ack_ph_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              if (sr[0]) begin
                // Read: snapshot reg[ptr] and present its MSB right away.
                state_nxt  = DATA_RD;
                sr_load    = 1'b1;
                rd_idx     = ptr;
                sda_oe_nxt = ~regs[ptr][7];
              end else begin
                state_nxt  = PTR;
                sda_oe_nxt = 1'b0;
              end
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            sr_shift_in = 1'b1;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_set    = 1'b1;
              state_nxt  = WR_ACK;
              ack_ph_nxt = 1'b0;
            end
          end
        end
        DATA_WR: begin
          if (scl_rise) begin
            sr_shift_in = 1'b1;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_wr     = 1'b1;
              ptr_inc    = 1'b1;
              state_nxt  = WR_ACK;
              ack_ph_nxt = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              ack_ph_nxt = 1'b1;
              sda_oe_nxt = 1'b1;
            end else begin
              ack_ph_nxt  = 1'b0;
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = DATA_WR;
            end
          end
        end
        DATA_RD: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              ack_ph_nxt  = 1'b0;
              state_nxt   = RD_ACK;
            end else begin
              sr_shift_out = 1'b1;
              sda_oe_nxt   = ~sr[6];
              bit_cnt_nxt  = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (!ack_ph) begin
            if (scl_rise) begin
              ptr_inc = 1'b1;
              if (!sda_f) begin
                // Controller ACKed: snapshot the next register now.
                sr_load    = 1'b1;
                rd_idx     = ptr + 4'd1;
                ack_ph_nxt = 1'b1;
              end else begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
              end
            end
          end else if (scl_fall) begin
            state_nxt   = DATA_RD;
            sda_oe_nxt  = ~sr[7];
            bit_cnt_nxt = '0;
            ack_ph_nxt  = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shift register: receive path, transmit path and read snapshot load.
  always_ff @(posedge clk_i) begin
    if (sr_load) begin
      sr <= regs[rd_idx];
    end else if (sr_shift_in) begin
      sr <= {sr[6:0], sda_f};
    end else if (sr_shift_out) begin
      sr <= {sr[6:0], 1'b0};
    end
  end

  // Register pointer and register file; the I2C write is last so it wins a collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      if (ptr_set) begin
        ptr <= rx_byte[3:0];
      end else if (ptr_inc) begin
        ptr <= ptr + 4'd1;
      end
      if (wb_wr_fire) regs[wb_adr_q] <= wb_dat_q;
      if (reg_wr)     regs[ptr]      <= rx_byte;
    end
  end

  assign wb_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wb_wr_fire = wb_ack_o & wb_we_q;

  // WISHBONE handshake: single-cycle ack, read data and write request captured at request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
      wb_we_q  <= 1'b0;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) begin
        wb_dat_o <= regs[wb_adr_i];
        wb_we_q  <= wb_we_i;
        wb_adr_q <= wb_adr_i;
        wb_dat_q <= wb_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller plus WISHBONE master,
// with queue scoreboards for WB read data, I2C read bytes and write pulses.
module tb_i2c_target_regs;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_cyc, wb_stb, wb_we, wb_sel;
  logic [3:0] wb_adr;
  logic [7:0] wb_dat_w;
  logic [7:0] wb_dat_r;
  logic       wb_ack, wb_err, wb_rty;
  logic       scl;
  logic       ctl_sda_low;
  wire        sda_bus;
  logic       i2c_wr;
  logic [3:0] i2c_wr_adr;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wb_exp [$];
  logic [7:0] rd_exp [$];
  logic [3:0] wr_exp [$];
  int         wr_pulses = 0;

  assign sda_bus = ctl_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target_regs #(.I2C_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel),
    .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty),
    .SCL(scl), .SDA(sda_bus),
    .i2c_wr_o(i2c_wr), .i2c_wr_adr_o(i2c_wr_adr), .busy_o(busy)
  );

  // Write-pulse monitor: every i2c_wr_o pulse pops the expected register index.
  always @(negedge clk) begin
    if (i2c_wr === 1'b1) begin
      wr_pulses++;
      checks++;
      if (wr_exp.size() == 0) begin
        failures++;
        $display("FAIL i2c_wr_unexpected got_adr=%0d required=none", i2c_wr_adr);
      end else begin
        logic [3:0] e;
        e = wr_exp.pop_front();
        if (i2c_wr_adr !== e) begin
          failures++;
          $display("FAIL i2c_wr_adr got=%0d required=%0d", i2c_wr_adr, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    wb_adr = a; wb_dat_w = d; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick(1);
    checks++;
    if (wb_ack !== 1'b1) begin failures++; $display("FAIL wb_wr_ack got=%b required=1", wb_ack); end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick(1);
    checks++;
    if (wb_ack !== 1'b0) begin failures++; $display("FAIL wb_wr_ack_width got=%b required=0", wb_ack); end
  endtask

  task automatic wb_read(input logic [3:0] a, input logic [7:0] exp_d);
    logic [7:0] e;
    wb_exp.push_back(exp_d);
    wb_adr = a; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick(1);
    checks++;
    if (wb_ack !== 1'b1) begin
      failures++; $display("FAIL wb_rd_ack got=%b required=1", wb_ack);
    end else begin
      e = wb_exp.pop_front();
      checks++;
      if (wb_dat_r !== e) begin
        failures++; $display("FAIL wb_rd_data adr=%0d got=%h required=%h", a, wb_dat_r, e);
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick(1);
    checks++;
    if (wb_ack !== 1'b0) begin failures++; $display("FAIL wb_rd_ack_width got=%b required=0", wb_ack); end
  endtask

  task automatic i2c_start();
    tick(Q); ctl_sda_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); ctl_sda_low = 1'b1;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); ctl_sda_low = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); ctl_sda_low = 1'b0;
    tick(2*Q);
  endtask

  // Sends one byte and returns the sampled ACK bit. With collide set, a WB write of
  // 0x66 to index 5 is timed so its ack-cycle write lands on the DUT's I2C write edge.
  task automatic i2c_write_byte(input logic [7:0] b, input bit collide, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      tick(Q); ctl_sda_low = ~b[i];
      tick(Q); scl = 1'b1;
      if (collide && i == 0) begin
        tick(4);
        wb_adr = 4'd5; wb_dat_w = 8'h66; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick(1);
        checks++;
        if (wb_ack !== 1'b1) begin failures++; $display("FAIL collision_wb_ack got=%b required=1", wb_ack); end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick(2*Q - 5);
      end else begin
        tick(2*Q);
      end
      scl = 1'b0;
    end
    tick(Q); ctl_sda_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); ack = sda_bus;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_read_byte(input bit nack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      tick(Q); ctl_sda_low = 1'b0;
      tick(Q); scl = 1'b1;
      tick(Q); b[i] = sda_bus;
      tick(Q); scl = 1'b0;
    end
    tick(Q); ctl_sda_low = ~nack;
    tick(Q); scl = 1'b1;
    tick(2*Q); scl = 1'b0;
  endtask

  task automatic expect_ack(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin failures++; $display("FAIL %s got=%b required=%b", name, got, req); end
  endtask

  task automatic test_reset();
    checks++; if (wb_ack !== 1'b0)    begin failures++; $display("FAIL rst_ack got=%b required=0", wb_ack); end
    checks++; if (wb_dat_r !== 8'h00) begin failures++; $display("FAIL rst_dat got=%h required=00", wb_dat_r); end
    checks++; if (wb_err !== 1'b0 || wb_rty !== 1'b0) begin failures++; $display("FAIL rst_err_rty got=%b%b required=00", wb_err, wb_rty); end
    checks++; if (i2c_wr !== 1'b0)    begin failures++; $display("FAIL rst_i2c_wr got=%b required=0", i2c_wr); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
    checks++; if (sda_bus !== 1'b1)   begin failures++; $display("FAIL rst_sda got=%b required=1", sda_bus); end
  endtask

  task automatic test_wb();
    wb_write(4'd3, 8'hA5);
    wb_read(4'd3, 8'hA5);
    wb_read(4'd4, 8'h00);
    checks++; if (wb_err !== 1'b0 || wb_rty !== 1'b0) begin failures++; $display("FAIL wb_err_rty got=%b%b required=00", wb_err, wb_rty); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    logic [7:0] e;
    wb_adr = 4'd3; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    wb_exp.push_back(8'hA5);
    wb_exp.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      exp_ack = (k % 2 == 0);
      checks++;
      if (wb_ack !== exp_ack) begin
        failures++; $display("FAIL b2b_ack cycle=%0d got=%b required=%b", k, wb_ack, exp_ack);
      end
      if (wb_ack === 1'b1 && wb_exp.size() != 0) begin
        e = wb_exp.pop_front();
        checks++;
        if (wb_dat_r !== e) begin failures++; $display("FAIL b2b_data got=%h required=%h", wb_dat_r, e); end
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick(1);
  endtask

  task automatic test_i2c_write();
    logic a;
    i2c_start();
    i2c_write_byte(8'hA0, 1'b0, a); expect_ack("wr_addr_ack", a, 1'b0);
    i2c_write_byte(8'h0E, 1'b0, a); expect_ack("wr_ptr_ack", a, 1'b0);
    wr_exp.push_back(4'd14);
    i2c_write_byte(8'h11, 1'b0, a); expect_ack("wr_d0_ack", a, 1'b0);
    wr_exp.push_back(4'd15);
    i2c_write_byte(8'h22, 1'b0, a); expect_ack("wr_d1_ack", a, 1'b0);
    wr_exp.push_back(4'd0);
    i2c_write_byte(8'h33, 1'b0, a); expect_ack("wr_d2_ack", a, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_active got=%b required=1", busy); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got=%b required=0", busy); end
    wb_read(4'd14, 8'h11);
    wb_read(4'd15, 8'h22);
    wb_read(4'd0,  8'h33);
    wb_read(4'd3,  8'hA5);
  endtask

  task automatic test_i2c_read();
    logic a;
    logic [7:0] b, e;
    rd_exp.push_back(8'h11);
    rd_exp.push_back(8'h22);
    rd_exp.push_back(8'h33);
    i2c_start();
    i2c_write_byte(8'hA0, 1'b0, a); expect_ack("rd_addrw_ack", a, 1'b0);
    i2c_write_byte(8'h0E, 1'b0, a); expect_ack("rd_ptr_ack", a, 1'b0);
    i2c_start();
    i2c_write_byte(8'hA1, 1'b0, a); expect_ack("rd_addrr_ack", a, 1'b0);
    for (int k = 0; k < 3; k++) begin
      i2c_read_byte(k == 2, b);
      e = rd_exp.pop_front();
      checks++;
      if (b !== e) begin failures++; $display("FAIL rd_byte%0d got=%h required=%h", k, b, e); end
    end
    tick(10);
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL rd_sda_after_nack got=%b required=1", sda_bus); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rd_busy_after_nack got=%b required=0", busy); end
    i2c_stop();
  endtask

  task automatic test_addr_mismatch();
    logic a;
    i2c_start();
    i2c_write_byte(8'hA2, 1'b0, a); expect_ack("mis_addr_nack", a, 1'b1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mis_busy got=%b required=0", busy); end
    i2c_write_byte(8'h77, 1'b0, a); expect_ack("mis_data_nack", a, 1'b1);
    i2c_stop();
    wb_read(4'd0,  8'h33);
    wb_read(4'd14, 8'h11);
  endtask

  task automatic test_collision();
    logic a;
    i2c_start();
    i2c_write_byte(8'hA0, 1'b0, a); expect_ack("col_addr_ack", a, 1'b0);
    i2c_write_byte(8'h05, 1'b0, a); expect_ack("col_ptr_ack", a, 1'b0);
    wr_exp.push_back(4'd5);
    i2c_write_byte(8'h55, 1'b1, a); expect_ack("col_data_ack", a, 1'b0);
    i2c_stop();
    wb_read(4'd5, 8'h55);
  endtask

  task automatic test_reset_mid_read();
    logic a;
    i2c_start();
    i2c_write_byte(8'hA0, 1'b0, a); expect_ack("mr_addrw_ack", a, 1'b0);
    i2c_write_byte(8'h0E, 1'b0, a); expect_ack("mr_ptr_ack", a, 1'b0);
    i2c_start();
    i2c_write_byte(8'hA1, 1'b0, a); expect_ack("mr_addrr_ack", a, 1'b0);
    // reg14 = 0x11, so the first data bit is a 0 that the target pulls low.
    for (int k = 0; k < 40 && sda_bus !== 1'b0; k++) tick(1);
    checks++;
    if (sda_bus !== 1'b0) begin failures++; $display("FAIL mr_drive_low got=%b required=0", sda_bus); end
    rst = 1'b1;
    #1;
    checks++;
    if (sda_bus !== 1'b1) begin failures++; $display("FAIL mr_sda_release got=%b required=1", sda_bus); end
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b required=0", busy); end
    scl = 1'b1;
    tick(2*Q);
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL mr_sda_idle got=%b required=1", sda_bus); end
    for (int r = 0; r < 16; r++) wb_read(4'(r), 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 1'b1;
    wb_adr = '0; wb_dat_w = '0;
    scl = 1'b1; ctl_sda_low = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    test_reset();
    test_wb();
    test_back_to_back();
    test_i2c_write();
    test_i2c_read();
    test_addr_mismatch();
    test_collision();
    test_reset_mid_read();
    tick(5);
    checks++;
    if (wr_pulses != 4 || wr_exp.size() != 0) begin
      failures++; $display("FAIL wr_pulse_count got=%0d required=4 pending=%0d", wr_pulses, wr_exp.size());
    end
    checks++;
    if (wb_exp.size() != 0 || rd_exp.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d/%0d required=0/0", wb_exp.size(), rd_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) exposing a 16 x 8-bit register file to an external I2C controller, with the same registers readable and writable by on-chip logic through a WISHBONE slave port. It is the far end of the board's I2C links. It lets FPGA status and configuration registers be reached by an off-board controller driving the standard write-pointer-then-data / repeated-start-read protocol. The block is a pure target: it never drives SCL and never stretches the clock.

## Interface
Parameters:
- I2C_ADDR, 7'h50: 7-bit target address matched in the address byte.
- FILTER_LEN, 3: consecutive identical samples required before a filtered SCL/SDA level changes.

Ports:
- clk_i  in  1  system clock; must be at least 20x the SCL frequency.
- rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  WISHBONE cycle.
- wb_stb_i  in  1  WISHBONE strobe.
- wb_we_i  in  1  WISHBONE write enable.
- wb_adr_i  in  4  register index.
- wb_dat_i  in  8  write data.
- wb_sel_i  in  1  byte select; ignored.
- wb_dat_o  out  8  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  tied 0.
- wb_rty_o  out  1  tied 0.
- SCL  in  1  I2C clock pin.
- SDA  inout  1  I2C data pin; open-drain, driven 0 or Z only.
- i2c_wr_o  out  1  one-cycle pulse when an I2C data byte is written to the register file.
- i2c_wr_adr_o  out  4  register index of that write; valid with i2c_wr_o.
- busy_o  out  1  high while this target is addressed (from address ACK until STOP, NACK or mismatch).

## Operation
Input conditioning:
- SCL and SDA each pass through a 2-FF synchronizer, then a FILTER_LEN-sample majority-free filter. The filtered level changes only after FILTER_LEN equal consecutive samples.
- Edge detect operates on the filtered levels.

Bus conditions:
- START or repeated START: filtered SDA falls while SCL is high.
- STOP: filtered SDA rises while SCL is high.
- Both are recognised in every state. START enters ADDR. STOP enters IDLE and releases SDA.

State machine (IDLE, ADDR, ADDR_ACK, PTR, DATA_WR, WR_ACK, DATA_RD, RD_ACK):
- ADDR shifts 8 bits MSB-first on SCL rising edges.
  - Bits[7:1] == I2C_ADDR → ADDR_ACK.
  - Mismatch → IDLE, SDA untouched.
- ADDR_ACK: drive SDA low on the next SCL falling edge and hold through the following SCL falling edge.
  - R/W=0 → PTR. The first byte after the address is the pointer.
  - R/W=1 → DATA_RD, with byte reg[ptr] loaded into the shift register.
- PTR: receive 8 bits, ptr <= byte[3:0] (bits [7:4] ignored), ACK, then DATA_WR.
- DATA_WR: receive a byte, then WR_ACK.
  - reg[ptr] <= byte, pulse i2c_wr_o with i2c_wr_adr_o = ptr.
  - ptr <= ptr+1, wrapping 15→0.
  - Return to DATA_WR.
- DATA_RD: drive the shift-register MSB after each SCL falling edge. Drive 0 as pull-low, 1 as release. Then RD_ACK.
- RD_ACK: release SDA and sample it on the SCL rising edge. ptr <= ptr+1, wrapping.
  - ACK (0) → load reg[ptr] and continue in DATA_RD.
  - NACK (1) → IDLE; wait for STOP or START.
- ptr persists across transactions. A read without a preceding pointer write starts at the last ptr.

WISHBONE port:
- Any cyc&stb with ack low gives wb_ack_o the next cycle, high for exactly one cycle.
- Reads return reg[wb_adr_i] sampled at request. Writes update reg[wb_adr_i] on the ack cycle.
- Back-to-back requests get ack every other cycle.
- Collision: if an I2C write and a WB write target the same register in the same cycle, the I2C write wins and the WB write is dropped (still acked).
- Read data being shifted out is a snapshot taken at load time.

## Timing
Reset values:
- State IDLE, ptr 0, all registers 8'h00.
- SDA released (Z), wb_ack_o 0, wb_dat_o 8'h00, i2c_wr_o 0, busy_o 0.

Latencies:
- Pin-to-filtered: 2 + FILTER_LEN cycles.
- SDA drive changes occur 1 cycle after a detected filtered SCL fall. That is well inside the low phase at ≥20x oversampling.

Reset mid-transaction:
- SDA releases in the reset cycle; state goes to IDLE.
- The controller's in-flight transfer then sees NACK or a floating bus.

Bus-condition edges:
- A START inside a byte aborts it. No register write, no ptr change.
- A STOP during ADDR_ACK or an ACK slot releases SDA immediately.

## Test plan
- Reset, then a WB write of 8'hA5 to index 3, then a WB read of index 3 → wb_dat_o = 8'hA5, ack one cycle after each request, err/rty 0.
- I2C write: START, 0xA0, ptr 0x0E, then 0x11, 0x22, 0x33, STOP → ACK on all five bytes; reg14=0x11, reg15=0x22, reg0=0x33 (wrap); three i2c_wr_o pulses with adr 14, 15, 0; busy_o falls at STOP.
- I2C combined read: START, 0xA0, ptr 0x0E, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP → bytes 0x11, 0x22, 0x33; SDA released after NACK.
- Address 0xA2 (mismatch) → no ACK (SDA stays high), no register change, busy_o stays 0.
- Same-cycle collision: I2C write of 0x55 to index 5 and WB write of 0x66 to index 5 → reg5 = 0x55, WB still acked.
- rst_i asserted mid read while the target drives SDA low → SDA released the same cycle, state IDLE, all registers 0x00.
